rbcp_reg_responder: RTL and testbench
=====================================

# rbcp_reg_responder

Responder (slave) end of the SiTCP RBCP local bus. It decodes RBCP write and read strobes, drives the one-cycle ACK with read data, and exposes a 16-byte register window to user logic. The window holds eight R/W control bytes, four snapshotted status bytes, a 16-bit saturating event counter, a scratch byte and an ID byte. It sits beside the SiTCP wrapper in the same CLK domain, wired directly to its RBCP_* ports.

## Interface
- BASE_ADDR, 32'h0000_0000: window base; must be 16-byte aligned.
- CTRL_INIT, 64'h0: reset value of CTRL[63:0]; byte n is at offset n.
- ID_VALUE, 8'hA5: constant returned at offset 0x0F.

Ports:
- CLK  in  1  system clock, same as the SiTCP core
- RSTn  in  1  asynchronous, active-low reset
- RBCP_ACT  in  1  RBCP transaction active
- RBCP_ADDR  in  32  access address
- RBCP_WD  in  8  write data
- RBCP_WE  in  1  write strobe, one-cycle pulse
- RBCP_RE  in  1  read strobe, one-cycle pulse
- RBCP_ACK  out  1  access acknowledge, one-cycle pulse
- RBCP_RD  out  8  read data, valid only while RBCP_ACK=1
- CTRL  out  64  control bytes, offsets 0x00-0x07
- CTRL_WR  out  8  one-hot write pulse per control byte, one cycle
- STATUS_IN  in  32  user status, offsets 0x08-0x0B
- EVT_IN  in  1  event pulse, counted once per high cycle

## Operation
- FSM states: IDLE, DECODE, ACK.
- IDLE: when RBCP_ACT=1 and (RBCP_WE or RBCP_RE) is high, latch ADDR, WD and op, then go to DECODE. If WE and RE are both high, the access is a write.
- DECODE: the access is in range when ADDR[31:4]==BASE_ADDR[31:4].
  - Out of range: go to IDLE and do not assert ACK. SiTCP times the access out.
  - In range: perform the write, or load the read mux into the RD register. Then go to ACK.
- ACK: drive RBCP_ACK=1 with RBCP_RD valid, then go to IDLE.
- Strobes that arrive in DECODE or ACK are ignored.
- If RBCP_ACT=0 while in DECODE: abort to IDLE. No write and no ACK.
- Offset map, offset = ADDR[3:0]:
  - 0x00-0x07: CTRL byte, R/W. A write updates the byte and pulses CTRL_WR[n].
  - 0x08-0x0B: STATUS byte, RO, writes are ACKed and ignored. STATUS_IN is registered into a 32-bit snapshot on every read of 0x08. Reads of 0x08-0x0B return snapshot bytes, so a 0x08..0x0B read sequence is coherent.
  - 0x0C: counter low byte.
    - Read: returns CNT[7:0] and captures CNT[15:8] into a shadow register.
    - Write: any value clears CNT to 0.
  - 0x0D: returns the shadow byte. RO.
  - 0x0E: scratch, R/W.
  - 0x0F: returns ID_VALUE. RO.
- Event counter CNT[15:0]:
  - Increments by 1 each cycle EVT_IN=1.
  - Saturates at 16'hFFFF; no wrap-around.
  - An EVT_IN in the same cycle as a clear: the clear wins, CNT=0, and that event is lost.

## Timing
- Strobe seen at cycle 0 → DECODE at cycle 1 → RBCP_ACK=1 at cycle 2. Latency is fixed at 2 cycles.
- The write takes effect at cycle 1 edge. CTRL and CTRL_WR change at the same edge, so CTRL_WR is high during cycle 2 with the new CTRL value visible.
- RBCP_RD is 8'h00 whenever RBCP_ACK=0.
- Reset values:
  - RBCP_ACK=0, RBCP_RD=0, CTRL=CTRL_INIT, CTRL_WR=0.
  - Scratch=0, CNT=0, shadow=0, status snapshot=0, FSM=IDLE.
- Back-to-back: a new strobe is accepted in IDLE, at the earliest cycle 3 after the previous strobe.
- Reset asserted mid-access: all state clears immediately and no ACK is issued. After release the block waits for a fresh strobe.

## Structure
- Package rbcp_reg_pkg:
  - Offset constants OFS_CTRL0..OFS_ID.
  - FSM state enum {IDLE, DECODE, ACK}.
  - Window size constant 16.
- Sub-module rbcp_evt_counter: saturating 16-bit counter with clear priority and a high-byte shadow capture input. It is natural to split out and reuse for further counters.
- The top holds the FSM, address decode, CTRL/scratch registers, status snapshot and the read mux. The whole block stays under 300 lines.

## Test plan
- Write 0x3C to BASE+0x02, then read BASE+0x02:
  - The write ACK comes 2 cycles after WE, with CTRL[23:16]=0x3C and CTRL_WR=8'b0000_0100 for one cycle.
  - The read ACK carries RD=0x3C.
- Read BASE+0x0F → ACK at cycle 2, RD=ID_VALUE. Write 0xFF to BASE+0x0F → ACK issued; a subsequent read still returns ID_VALUE.
- Access BASE+0x10 and BASE-1, both read and write → no ACK within 100 cycles; CTRL unchanged.
- Counter:
  - Pulse EVT_IN 300 times, read 0x0C then 0x0D → 0x2C, 0x01.
  - Hold EVT_IN high for 70000 cycles → reads return 0xFF, 0xFF.
  - Write 0x0C in the same cycle as EVT_IN=1 → CNT=0.
- WE and RE in the same cycle at BASE+0x0E with WD=0x5A → treated as a write, exactly one ACK, and a later read returns 0x5A.
- Protocol abort and reset:
  - Drop RBCP_ACT in the cycle after WE → no ACK and no CTRL change.
  - Assert RSTn=0 in DECODE → RBCP_ACK stays 0, CTRL returns to CTRL_INIT.

Source files
------------

// File: rtl/rbcp_reg_pkg.sv
// Shared constants and types for the RBCP register responder.
// Offsets are relative to the 16-byte window base.
package rbcp_reg_pkg;

  localparam int WIN_SIZE = 16;

  localparam logic [3:0] OFS_CTRL0   = 4'h0;
  localparam logic [3:0] OFS_CTRL7   = 4'h7;
  localparam logic [3:0] OFS_STAT0   = 4'h8;
  localparam logic [3:0] OFS_STAT3   = 4'hB;
  localparam logic [3:0] OFS_CNT_LO  = 4'hC;
  localparam logic [3:0] OFS_CNT_HI  = 4'hD;
  localparam logic [3:0] OFS_SCRATCH = 4'hE;
  localparam logic [3:0] OFS_ID      = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ACK
  } rbcp_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        we;
  } rbcp_req_t;

  function automatic logic in_window(input logic [27:0] addr_hi, input logic [27:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/rbcp_evt_counter.sv
// Saturating 16-bit event counter, clear beats a coincident event; 1-cycle update.
// No backpressure: evt is sampled every cycle, capture latches cnt[15:8] into shadow.
module rbcp_evt_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt,
  input  logic        clr,
  input  logic        capture,
  output logic [15:0] cnt,
  output logic [7:0]  shadow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 16'h0000;
      shadow <= 8'h00;
    end else begin
      if (clr) begin
        cnt <= 16'h0000;
      end else if (evt && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'h0001;
      end
      if (capture) begin
        shadow <= cnt[15:8];
      end
    end
  end

endmodule

// File: rtl/rbcp_reg_responder.sv
// SiTCP RBCP responder exposing a 16-byte register window; ACK 2 cycles after strobe.
// No backpressure: strobes arriving outside IDLE are dropped, out-of-range accesses get no ACK.
module rbcp_reg_responder
  import rbcp_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [63:0] CTRL_INIT = 64'h0,
  parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        RBCP_ACT,
  input  logic [31:0] RBCP_ADDR,
  input  logic [7:0]  RBCP_WD,
  input  logic        RBCP_WE,
  input  logic        RBCP_RE,
  output logic        RBCP_ACK,
  output logic [7:0]  RBCP_RD,
  output logic [63:0] CTRL,
  output logic [7:0]  CTRL_WR,
  input  logic [31:0] STATUS_IN,
  input  logic        EVT_IN
);

  rbcp_state_t state;
  rbcp_req_t   req;
  logic [7:0]  scratch;
  logic [31:0] status_snap;
  logic [15:0] cnt;
  logic [7:0]  cnt_shadow;

  logic [3:0]  ofs;
  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic        cnt_clr;
  logic        cnt_cap;
  logic [31:0] status_view;
  logic [7:0]  rd_mux;

  assign ofs     = req.addr[3:0];
  assign hit     = (state == DECODE) && RBCP_ACT && in_window(req.addr[31:4], BASE_ADDR[31:4]);
  assign wr_hit  = hit && req.we;
  assign rd_hit  = hit && !req.we;
  assign cnt_clr = wr_hit && (ofs == OFS_CNT_LO);
  assign cnt_cap = rd_hit && (ofs == OFS_CNT_LO);

  // A read of the first status byte returns the live value that is being snapshotted.
  assign status_view = (ofs == OFS_STAT0) ? STATUS_IN : status_snap;

  always_comb begin
    rd_mux = 8'h00;
    if (ofs <= OFS_CTRL7) begin
      rd_mux = CTRL[{ofs[2:0], 3'b000} +: 8];
    end else if (ofs <= OFS_STAT3) begin
      rd_mux = status_view[{ofs[1:0], 3'b000} +: 8];
    end else begin
      case (ofs)
        OFS_CNT_LO:  rd_mux = cnt[7:0];
        OFS_CNT_HI:  rd_mux = cnt_shadow;
        OFS_SCRATCH: rd_mux = scratch;
        OFS_ID:      rd_mux = ID_VALUE;
        default:     rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      req         <= '0;
      RBCP_ACK    <= 1'b0;
      RBCP_RD     <= 8'h00;
      CTRL        <= CTRL_INIT;
      CTRL_WR     <= 8'h00;
      scratch     <= 8'h00;
      status_snap <= 32'h0;
    end else begin
      RBCP_ACK <= 1'b0;
      RBCP_RD  <= 8'h00;
      CTRL_WR  <= 8'h00;
      case (state)
        IDLE: begin
          if (RBCP_ACT && (RBCP_WE || RBCP_RE)) begin
            req.addr <= RBCP_ADDR;
            req.wd   <= RBCP_WD;
            req.we   <= RBCP_WE;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (hit) begin
            RBCP_ACK <= 1'b1;
            state    <= ACK;
            if (req.we) begin
              if (ofs <= OFS_CTRL7) begin
                CTRL[{ofs[2:0], 3'b000} +: 8] <= req.wd;
                CTRL_WR[ofs[2:0]]             <= 1'b1;
              end else if (ofs == OFS_SCRATCH) begin
                scratch <= req.wd;
              end
            end else begin
              RBCP_RD <= rd_mux;
              if (ofs == OFS_STAT0) begin
                status_snap <= STATUS_IN;
              end
            end
          end else begin
            // Out of range or ACT dropped: SiTCP times the access out.
            state <= IDLE;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  rbcp_evt_counter u_evt_counter (
    .clk     (CLK),
    .rst_n   (RSTn),
    .evt     (EVT_IN),
    .clr     (cnt_clr),
    .capture (cnt_cap),
    .cnt     (cnt),
    .shadow  (cnt_shadow)
  );

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Directed bench for rbcp_reg_responder: register map, ACK timing, counter, abort and reset.
module tb_rbcp_reg_responder;

  localparam logic [31:0] BASE = 32'h1000_0120;
  localparam logic [63:0] CINIT = 64'h0807_0605_0403_0201;
  localparam logic [7:0]  IDV = 8'hA5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        act = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [7:0]  wd = 8'h00;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        ack;
  logic [7:0]  rd;
  logic [63:0] ctrl;
  logic [7:0]  ctrl_wr;
  logic [31:0] status_in = 32'h0;
  logic        evt = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rbcp_reg_responder #(
    .BASE_ADDR (BASE),
    .CTRL_INIT (CINIT),
    .ID_VALUE  (IDV)
  ) dut (
    .CLK       (clk),
    .RSTn      (rstn),
    .RBCP_ACT  (act),
    .RBCP_ADDR (addr),
    .RBCP_WD   (wd),
    .RBCP_WE   (we),
    .RBCP_RE   (re),
    .RBCP_ACK  (ack),
    .RBCP_RD   (rd),
    .CTRL      (ctrl),
    .CTRL_WR   (ctrl_wr),
    .STATUS_IN (status_in),
    .EVT_IN    (evt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access with strobes at cycle 0; ACK must appear exactly at cycle 2.
  task automatic access(input logic [31:0] a, input logic [7:0] d, input logic w, input logic r,
                        input string tag, output logic [7:0] rd_o, output logic [7:0] wr_o,
                        output logic [63:0] ctrl_o);
    @(negedge clk);
    act = 1'b1; addr = a; wd = d; we = w; re = r;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk({tag, "_ack_c1"}, {63'h0, ack}, 64'h0);
    chk({tag, "_rd_c1"}, {56'h0, rd}, 64'h0);
    @(negedge clk);
    chk({tag, "_ack_c2"}, {63'h0, ack}, 64'h1);
    rd_o = rd; wr_o = ctrl_wr; ctrl_o = ctrl;
    @(negedge clk);
    chk({tag, "_ack_c3"}, {63'h0, ack}, 64'h0);
    chk({tag, "_rd_c3"}, {56'h0, rd}, 64'h0);
    chk({tag, "_wr_c3"}, {56'h0, ctrl_wr}, 64'h0);
    act = 1'b0;
  endtask

  task automatic no_ack(input logic [31:0] a, input logic w, input logic r, input string tag);
    int acks;
    acks = 0;
    @(negedge clk);
    act = 1'b1; addr = a; wd = 8'hEE; we = w; re = r;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    act = 1'b0;
    chk({tag, "_noack"}, 64'(acks), 64'h0);
  endtask

  logic [7:0]  rv;
  logic [7:0]  wv;
  logic [63:0] cv;
  int          n;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", {63'h0, ack}, 64'h0);
    chk("rst_rd", {56'h0, rd}, 64'h0);
    chk("rst_ctrl", ctrl, CINIT);
    chk("rst_ctrl_wr", {56'h0, ctrl_wr}, 64'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // CTRL write/read
    access(BASE + 32'h2, 8'h3C, 1'b1, 1'b0, "wr_c2", rv, wv, cv);
    chk("wr_c2_strobe", {56'h0, wv}, 64'h04);
    chk("wr_c2_ctrl", cv, 64'h0807_0605_043C_0201);
    access(BASE + 32'h2, 8'h00, 1'b0, 1'b1, "rd_c2", rv, wv, cv);
    chk("rd_c2_data", {56'h0, rv}, 64'h3C);

    // ID register is read-only
    access(BASE + 32'hF, 8'h00, 1'b0, 1'b1, "rd_id", rv, wv, cv);
    chk("rd_id_data", {56'h0, rv}, {56'h0, IDV});
    access(BASE + 32'hF, 8'hFF, 1'b1, 1'b0, "wr_id", rv, wv, cv);
    chk("wr_id_strobe", {56'h0, wv}, 64'h0);
    access(BASE + 32'hF, 8'h00, 1'b0, 1'b1, "rd_id2", rv, wv, cv);
    chk("rd_id2_data", {56'h0, rv}, {56'h0, IDV});
    access(BASE + 32'hE, 8'h00, 1'b0, 1'b1, "rd_scr0", rv, wv, cv);
    chk("rd_scr0_data", {56'h0, rv}, 64'h0);

    // Out of range
    no_ack(BASE + 32'h10, 1'b0, 1'b1, "oor_hi_rd");
    no_ack(BASE + 32'h10, 1'b1, 1'b0, "oor_hi_wr");
    no_ack(BASE - 32'h1, 1'b0, 1'b1, "oor_lo_rd");
    no_ack(BASE - 32'h1, 1'b1, 1'b0, "oor_lo_wr");
    chk("oor_ctrl", ctrl, 64'h0807_0605_043C_0201);

    // Status snapshot coherence
    status_in = 32'hDDCC_BBAA;
    access(BASE + 32'h8, 8'h00, 1'b0, 1'b1, "rd_st0", rv, wv, cv);
    chk("rd_st0_data", {56'h0, rv}, 64'hAA);
    status_in = 32'h1122_3344;
    access(BASE + 32'h9, 8'h00, 1'b0, 1'b1, "rd_st1", rv, wv, cv);
    chk("rd_st1_data", {56'h0, rv}, 64'hBB);
    access(BASE + 32'hB, 8'h77, 1'b1, 1'b0, "wr_st3", rv, wv, cv);
    access(BASE + 32'hB, 8'h00, 1'b0, 1'b1, "rd_st3", rv, wv, cv);
    chk("rd_st3_data", {56'h0, rv}, 64'hDD);

    // Counter: 300 pulses -> 0x012C
    access(BASE + 32'hC, 8'h00, 1'b1, 1'b0, "clr0", rv, wv, cv);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); evt = 1'b1;
      @(negedge clk); evt = 1'b0;
    end
    access(BASE + 32'hC, 8'h00, 1'b0, 1'b1, "rd_cnt_lo", rv, wv, cv);
    chk("rd_cnt_lo_data", {56'h0, rv}, 64'h2C);
    access(BASE + 32'hD, 8'h00, 1'b0, 1'b1, "rd_cnt_hi", rv, wv, cv);
    chk("rd_cnt_hi_data", {56'h0, rv}, 64'h01);

    // Saturation
    @(negedge clk); evt = 1'b1;
    repeat (70000) @(negedge clk);
    evt = 1'b0;
    access(BASE + 32'hC, 8'h00, 1'b0, 1'b1, "rd_sat_lo", rv, wv, cv);
    chk("rd_sat_lo_data", {56'h0, rv}, 64'hFF);
    access(BASE + 32'hD, 8'h00, 1'b0, 1'b1, "rd_sat_hi", rv, wv, cv);
    chk("rd_sat_hi_data", {56'h0, rv}, 64'hFF);

    // Clear beats a coincident event (EVT high in strobe and DECODE cycles)
    @(negedge clk);
    act = 1'b1; addr = BASE + 32'hC; wd = 8'h00; we = 1'b1; evt = 1'b1;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    evt = 1'b0;
    chk("clr_evt_ack", {63'h0, ack}, 64'h1);
    @(negedge clk);
    act = 1'b0;
    access(BASE + 32'hC, 8'h00, 1'b0, 1'b1, "rd_clr_lo", rv, wv, cv);
    chk("rd_clr_lo_data", {56'h0, rv}, 64'h00);
    access(BASE + 32'hD, 8'h00, 1'b0, 1'b1, "rd_clr_hi", rv, wv, cv);
    chk("rd_clr_hi_data", {56'h0, rv}, 64'h00);

    // WE and RE together is a write
    access(BASE + 32'hE, 8'h5A, 1'b1, 1'b1, "wrrd_scr", rv, wv, cv);
    chk("wrrd_scr_rd", {56'h0, rv}, 64'h00);
    access(BASE + 32'hE, 8'h00, 1'b0, 1'b1, "rd_scr", rv, wv, cv);
    chk("rd_scr_data", {56'h0, rv}, 64'h5A);

    // ACT drops in DECODE
    n = 0;
    @(negedge clk);
    act = 1'b1; addr = BASE + 32'h3; wd = 8'h77; we = 1'b1;
    @(negedge clk);
    we = 1'b0; act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ack) n++;
      @(negedge clk);
    end
    chk("abort_noack", 64'(n), 64'h0);
    chk("abort_ctrl", ctrl, 64'h0807_0605_043C_0201);

    // Reset while in DECODE
    n = 0;
    @(negedge clk);
    act = 1'b1; addr = BASE + 32'h0; wd = 8'hEE; we = 1'b1;
    @(negedge clk);
    we = 1'b0; rstn = 1'b0;
    #1;
    chk("rst_mid_ctrl", ctrl, CINIT);
    for (int i = 0; i < 10; i++) begin
      if (ack) n++;
      if (i == 4) rstn = 1'b1;
      @(negedge clk);
    end
    act = 1'b0;
    chk("rst_mid_noack", 64'(n), 64'h0);
    access(BASE + 32'h0, 8'h00, 1'b0, 1'b1, "rd_after_rst", rv, wv, cv);
    chk("rd_after_rst_data", {56'h0, rv}, 64'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
